// File: rtl/bp_cce_spec_wr_arbiter.sv
// Write-port arbiter for the CCE speculation-bits array.
// Shares the single write port between the microcode engine and the
// memory-response path, and runs a clear sequence over every way group
// after reset or on request.

package bp_cce_spec_pkg;

   // Per-way-group speculation metadata
   typedef struct packed {
      logic       spec;
      logic       squash;
      logic       fwd_mod;
      logic [2:0] state;
   } bp_cce_spec_s;

endpackage

module bp_cce_spec_wr_arbiter
   import bp_cce_spec_pkg::*;
#(
   parameter int num_way_groups_p = 8,
   parameter int addr_width_p     = 40,
   parameter int starve_limit_p   = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    clear_i,

   input  logic                    ucode_v_i,
   output logic                    ucode_ready_o,
   input  logic [addr_width_p-1:0] ucode_addr_i,
   input  logic                    ucode_bypass_hash_i,
   input  logic [3:0]              ucode_field_v_i,
   input  bp_cce_spec_s            ucode_spec_i,

   input  logic                    mem_v_i,
   output logic                    mem_ready_o,
   input  logic [addr_width_p-1:0] mem_addr_i,
   input  logic                    mem_bypass_hash_i,
   input  logic [3:0]              mem_field_v_i,
   input  bp_cce_spec_s            mem_spec_i,

   output logic                    w_v_o,
   output logic [addr_width_p-1:0] w_addr_o,
   output logic                    w_addr_bypass_hash_o,
   output logic                    spec_v_o,
   output logic                    squash_v_o,
   output logic                    fwd_mod_v_o,
   output logic                    state_v_o,
   output bp_cce_spec_s            spec_o,
   output logic                    busy_o,
   output logic                    clear_done_o
);

   localparam int lg_num_way_groups_lp =
      (num_way_groups_p > 1) ? $clog2(num_way_groups_p) : 1;
   localparam int starve_width_lp =
      (starve_limit_p + 1 > 1) ? $clog2(starve_limit_p + 1) : 1;

   localparam logic [lg_num_way_groups_lp-1:0] clear_last_lp =
      lg_num_way_groups_lp'(num_way_groups_p - 1);
   localparam logic [starve_width_lp-1:0] starve_limit_lp =
      starve_width_lp'(starve_limit_p);

   typedef enum logic [1:0] {
      e_reset,
      e_clear,
      e_ready
   } state_e;

   state_e                          state_r, state_n;
   logic [lg_num_way_groups_lp-1:0] clear_cnt_r;
   logic [starve_width_lp-1:0]      starve_cnt_r;
   logic                            clear_done_r;
   logic                            ucode_grant;
   logic                            mem_grant;

   wire clear_last = (clear_cnt_r == clear_last_lp);

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_r <= e_reset;
      else         state_r <= state_n;
   end

   // Next-state logic: reset wins from any state
   always_comb begin
      state_n = state_r;
      unique case (state_r)
         e_reset: state_n = e_clear;
         e_clear: if (clear_last) state_n = e_ready;
         e_ready: if (clear_i) state_n = e_clear;
         default: state_n = e_reset;
      endcase
      if (reset_i) state_n = e_reset;
   end

   // Clear counter, registered clear-done pulse and ucode starvation counter
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         clear_cnt_r  <= '0;
         clear_done_r <= 1'b0;
         starve_cnt_r <= '0;
      end else begin
         clear_done_r <= (state_r == e_clear) && clear_last;
         if (state_r == e_clear)
            clear_cnt_r <= clear_last ? '0 : clear_cnt_r + 1'b1;
         // Starvation tracking only moves while arbitrating; it holds through CLEAR
         if (state_r == e_ready) begin
            if (!ucode_v_i || ucode_grant)
               starve_cnt_r <= '0;
            else if (starve_cnt_r != starve_limit_lp)
               starve_cnt_r <= starve_cnt_r + 1'b1;
         end
      end
   end

   // Output logic: clear writes, arbitration and write-port muxing
   // NOTE: every output gets a default first so no path leaves one
   // unassigned, which would infer a latch.
   always_comb begin
      ucode_grant          = 1'b0;
      mem_grant            = 1'b0;
      ucode_ready_o        = 1'b0;
      mem_ready_o          = 1'b0;
      w_v_o                = 1'b0;
      w_addr_o             = '0;
      w_addr_bypass_hash_o = 1'b0;
      {state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o} = 4'b0000;
      spec_o               = '0;
      busy_o               = 1'b0;
      clear_done_o         = 1'b0;

      unique case (state_r)
         e_reset: busy_o = 1'b1;
         e_clear: begin
            busy_o               = 1'b1;
            w_v_o                = 1'b1;
            w_addr_bypass_hash_o = 1'b1;
            w_addr_o             = addr_width_p'(clear_cnt_r);
            {state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o} = 4'b1111;
         end
         e_ready: begin
            clear_done_o = clear_done_r;
            // A clear request steals the port for this cycle
            if (!clear_i) begin
               ucode_grant = ucode_v_i && (!mem_v_i || (starve_cnt_r == starve_limit_lp));
               mem_grant   = mem_v_i && !ucode_grant;
            end
            ucode_ready_o = ucode_grant;
            mem_ready_o   = mem_grant;
            if (ucode_grant) begin
               w_v_o                = 1'b1;
               w_addr_o             = ucode_addr_i;
               w_addr_bypass_hash_o = ucode_bypass_hash_i;
               {state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o} = ucode_field_v_i;
               spec_o               = ucode_spec_i;
            end else if (mem_grant) begin
               w_v_o                = 1'b1;
               w_addr_o             = mem_addr_i;
               w_addr_bypass_hash_o = mem_bypass_hash_i;
               {state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o} = mem_field_v_i;
               spec_o               = mem_spec_i;
            end
         end
         default: busy_o = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_bp_cce_spec_wr_arbiter.sv
// Self-checking bench for bp_cce_spec_wr_arbiter: directed scenarios plus
// randomized traffic, all compared against a behavioural model of the
// arbiter's rules kept in this file.

module tb_bp_cce_spec_wr_arbiter;
   import bp_cce_spec_pkg::*;

   localparam int NWG   = 8;
   localparam int AW    = 16;
   localparam int LIMIT = 3;

   logic         clk_i = 1'b0;
   logic         reset_i, clear_i;
   logic         ucode_v_i, ucode_ready_o, ucode_bypass_hash_i;
   logic [AW-1:0] ucode_addr_i;
   logic [3:0]   ucode_field_v_i;
   bp_cce_spec_s ucode_spec_i;
   logic         mem_v_i, mem_ready_o, mem_bypass_hash_i;
   logic [AW-1:0] mem_addr_i;
   logic [3:0]   mem_field_v_i;
   bp_cce_spec_s mem_spec_i;
   logic         w_v_o, w_addr_bypass_hash_o;
   logic [AW-1:0] w_addr_o;
   logic         spec_v_o, squash_v_o, fwd_mod_v_o, state_v_o;
   bp_cce_spec_s spec_o;
   logic         busy_o, clear_done_o;

   int n_checks = 0;
   int n_fail   = 0;

   bp_cce_spec_wr_arbiter #(
      .num_way_groups_p(NWG),
      .addr_width_p    (AW),
      .starve_limit_p  (LIMIT)
   ) dut (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .clear_i             (clear_i),
      .ucode_v_i           (ucode_v_i),
      .ucode_ready_o       (ucode_ready_o),
      .ucode_addr_i        (ucode_addr_i),
      .ucode_bypass_hash_i (ucode_bypass_hash_i),
      .ucode_field_v_i     (ucode_field_v_i),
      .ucode_spec_i        (ucode_spec_i),
      .mem_v_i             (mem_v_i),
      .mem_ready_o         (mem_ready_o),
      .mem_addr_i          (mem_addr_i),
      .mem_bypass_hash_i   (mem_bypass_hash_i),
      .mem_field_v_i       (mem_field_v_i),
      .mem_spec_i          (mem_spec_i),
      .w_v_o               (w_v_o),
      .w_addr_o            (w_addr_o),
      .w_addr_bypass_hash_o(w_addr_bypass_hash_o),
      .spec_v_o            (spec_v_o),
      .squash_v_o          (squash_v_o),
      .fwd_mod_v_o         (fwd_mod_v_o),
      .state_v_o           (state_v_o),
      .spec_o              (spec_o),
      .busy_o              (busy_o),
      .clear_done_o        (clear_done_o)
   );

   always #5 clk_i = ~clk_i;

   // Every DUT output packed into one vector for whole-cycle comparison
   wire [31:0] act_vec = {w_v_o, w_addr_o, w_addr_bypass_hash_o,
                          state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o,
                          spec_o, busy_o, clear_done_o, ucode_ready_o, mem_ready_o};

   // ---------------- behavioural model ----------------
   bit m_in_reset  = 1'b1;
   int m_clear_left = 0;   // clear writes still to issue
   int m_starve    = 0;
   bit m_done      = 1'b0; // clear just finished

   function automatic bit model_ucode_wins();
      return ucode_v_i && (!mem_v_i || m_starve == LIMIT);
   endfunction

   function automatic logic [31:0] model_out();
      logic wv, byp, busy, done, ur, mr;
      logic [AW-1:0] a;
      logic [3:0] en;
      bp_cce_spec_s s;
      {wv, byp, busy, done, ur, mr} = '0;
      a = '0; en = '0; s = '0;
      if (m_in_reset) begin
         busy = 1'b1;
      end else if (m_clear_left > 0) begin
         wv = 1'b1; byp = 1'b1; en = 4'hF; busy = 1'b1;
         a = AW'(NWG - m_clear_left);
      end else begin
         done = m_done;
         if (!clear_i) begin
            ur = model_ucode_wins();
            mr = mem_v_i && !ur;
         end
         if (ur) begin
            wv = 1'b1; a = ucode_addr_i; byp = ucode_bypass_hash_i;
            en = ucode_field_v_i; s = ucode_spec_i;
         end else if (mr) begin
            wv = 1'b1; a = mem_addr_i; byp = mem_bypass_hash_i;
            en = mem_field_v_i; s = mem_spec_i;
         end
      end
      return {wv, a, byp, en, s, busy, done, ur, mr};
   endfunction

   // Advance one clock edge and update the model from the sampled inputs
   task automatic advance();
      bit ug;
      @(posedge clk_i);
      ug = !m_in_reset && m_clear_left == 0 && !clear_i && model_ucode_wins();
      if (reset_i) begin
         m_in_reset = 1'b1; m_clear_left = 0; m_starve = 0; m_done = 1'b0;
      end else if (m_in_reset) begin
         m_in_reset = 1'b0; m_clear_left = NWG; m_done = 1'b0;
      end else if (m_clear_left > 0) begin
         m_clear_left--;
         m_done = (m_clear_left == 0);
      end else begin
         m_done = 1'b0;
         if (clear_i) m_clear_left = NWG;
         if (!ucode_v_i || ug) m_starve = 0;
         else if (m_starve < LIMIT) m_starve++;
      end
      #1;
   endtask

   task automatic idle_inputs();
      clear_i = 0; ucode_v_i = 0; mem_v_i = 0;
      ucode_addr_i = '0; ucode_bypass_hash_i = 0; ucode_field_v_i = '0; ucode_spec_i = '0;
      mem_addr_i = '0; mem_bypass_hash_i = 0; mem_field_v_i = '0; mem_spec_i = '0;
   endtask

   task automatic rand_ucode();
      ucode_addr_i        = AW'($urandom);
      ucode_bypass_hash_i = 1'($urandom);
      ucode_field_v_i     = 4'($urandom);
      ucode_spec_i        = bp_cce_spec_s'(6'($urandom));
   endtask

   task automatic rand_mem();
      mem_addr_i        = AW'($urandom);
      mem_bypass_hash_i = 1'($urandom);
      mem_field_v_i     = 4'($urandom);
      mem_spec_i        = bp_cce_spec_s'(6'($urandom));
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] exp;
      idle_inputs();
      reset_i = 1;
      advance();                         // first edge puts the DUT in a known state
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i); exp = model_out(); n_checks++;
         if (act_vec !== exp) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", act_vec, exp); end
         advance();
      end
      reset_i = 0;
      @(negedge clk_i); n_checks++;
      if ({w_v_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL reset_release: got w_v/busy %b expected 01", {w_v_o, busy_o}); end
      advance();
      for (int i = 0; i < NWG; i++) begin
         @(negedge clk_i); exp = model_out(); n_checks++;
         if (act_vec !== exp) begin n_fail++; $display("FAIL reset_clear_model[%0d]: got %h expected %h", i, act_vec, exp); end
         n_checks++;
         if ({w_v_o, w_addr_bypass_hash_o, state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o, spec_o, w_addr_o} !==
             {6'b111111, 6'b0, AW'(i)}) begin
            n_fail++; $display("FAIL reset_clear_addr[%0d]: got addr %0d w_v %b", i, w_addr_o, w_v_o);
         end
         advance();
      end
      @(negedge clk_i); n_checks++;
      if ({busy_o, clear_done_o} !== 2'b01) begin n_fail++; $display("FAIL clear_done_pulse: got busy/done %b expected 01", {busy_o, clear_done_o}); end
      advance();
      @(negedge clk_i); n_checks++;
      if ({busy_o, clear_done_o} !== 2'b00) begin n_fail++; $display("FAIL clear_done_once: got busy/done %b expected 00", {busy_o, clear_done_o}); end
      advance();
   endtask

   task automatic test_ucode_only();
      idle_inputs();
      ucode_v_i = 1; ucode_addr_i = 16'h1000; ucode_field_v_i = 4'b0001;
      ucode_spec_i = '0; ucode_spec_i.spec = 1'b1;
      @(negedge clk_i); n_checks++;
      if ({ucode_ready_o, mem_ready_o, w_v_o, w_addr_o, state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o, spec_o.spec} !==
          {3'b101, 16'h1000, 4'b0001, 1'b1}) begin
         n_fail++; $display("FAIL ucode_only: got rdy %b w_v %b addr %h en %b", ucode_ready_o, w_v_o, w_addr_o,
                            {state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o});
      end
      advance();
      idle_inputs();
      @(negedge clk_i); n_checks++;
      if ({w_v_o, state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o} !== 5'b0) begin
         n_fail++; $display("FAIL idle_no_write: got w_v %b en %b expected 0", w_v_o, {state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o});
      end
      advance();
   endtask

   task automatic test_conflict();
      logic [31:0] exp;
      logic [7:0] want_u = 8'b1000_1000;  // bit i = ucode wins cycle i
      idle_inputs();
      ucode_v_i = 1; mem_v_i = 1;
      for (int i = 0; i < 8; i++) begin
         rand_ucode(); rand_mem();
         @(negedge clk_i); exp = model_out(); n_checks++;
         if (act_vec !== exp) begin n_fail++; $display("FAIL conflict_model[%0d]: got %h expected %h", i, act_vec, exp); end
         n_checks++;
         if ({ucode_ready_o, mem_ready_o} !== {want_u[i], ~want_u[i]}) begin
            n_fail++; $display("FAIL conflict_grant[%0d]: got u/m %b%b expected %b%b", i, ucode_ready_o, mem_ready_o, want_u[i], ~want_u[i]);
         end
         advance();
      end
   endtask

   task automatic test_clear_pulse();
      logic [31:0] exp;
      idle_inputs();
      ucode_v_i = 1; mem_v_i = 1; rand_ucode(); rand_mem();
      clear_i = 1;
      @(negedge clk_i); n_checks++;
      if ({w_v_o, ucode_ready_o, mem_ready_o} !== 3'b000) begin
         n_fail++; $display("FAIL clear_pulse_nogrant: got w_v/u/m %b expected 000", {w_v_o, ucode_ready_o, mem_ready_o});
      end
      advance();
      clear_i = 0;
      for (int i = 0; i < NWG; i++) begin
         @(negedge clk_i); exp = model_out(); n_checks++;
         if (act_vec !== exp) begin n_fail++; $display("FAIL clear_pulse_model[%0d]: got %h expected %h", i, act_vec, exp); end
         n_checks++;
         if ({ucode_ready_o, mem_ready_o, busy_o, w_addr_o} !== {3'b001, AW'(i)}) begin
            n_fail++; $display("FAIL clear_pulse_seq[%0d]: got u/m/busy %b addr %0d", i, {ucode_ready_o, mem_ready_o, busy_o}, w_addr_o);
         end
         advance();
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i); exp = model_out(); n_checks++;
         if (act_vec !== exp) begin n_fail++; $display("FAIL clear_pulse_resume[%0d]: got %h expected %h", i, act_vec, exp); end
         advance();
      end
   endtask

   task automatic test_reset_mid_clear();
      idle_inputs();
      clear_i = 1;
      advance();
      clear_i = 0;
      for (int i = 0; i < 4; i++) advance();
      reset_i = 1;
      @(negedge clk_i); n_checks++;
      if ({w_v_o, w_addr_o} !== {1'b1, AW'(4)}) begin
         n_fail++; $display("FAIL mid_clear_at4: got w_v %b addr %0d expected 1/4", w_v_o, w_addr_o);
      end
      advance();
      @(negedge clk_i); n_checks++;
      if ({w_v_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL mid_clear_reset: got w_v/busy %b expected 01", {w_v_o, busy_o}); end
      reset_i = 0;
      advance();
      for (int i = 0; i < NWG; i++) begin
         @(negedge clk_i); n_checks++;
         if ({w_v_o, busy_o, w_addr_o} !== {2'b11, AW'(i)}) begin
            n_fail++; $display("FAIL mid_clear_restart[%0d]: got w_v/busy %b addr %0d", i, {w_v_o, busy_o}, w_addr_o);
         end
         advance();
      end
      @(negedge clk_i); n_checks++;
      if ({w_v_o, busy_o, clear_done_o} !== 3'b001) begin
         n_fail++; $display("FAIL mid_clear_done: got w_v/busy/done %b expected 001", {w_v_o, busy_o, clear_done_o});
      end
      advance();
   endtask

   task automatic test_mem_fields();
      bp_cce_spec_s want;
      idle_inputs();
      rand_mem();
      mem_v_i = 1; mem_field_v_i = 4'b1010;
      want = mem_spec_i;
      @(negedge clk_i); n_checks++;
      if ({mem_ready_o, w_v_o, state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o, spec_o, w_addr_o} !==
          {2'b11, 4'b1010, want, mem_addr_i}) begin
         n_fail++; $display("FAIL mem_fields: got rdy %b en %b spec %h expected en 1010 spec %h", mem_ready_o,
                            {state_v_o, fwd_mod_v_o, squash_v_o, spec_v_o}, spec_o, want);
      end
      advance();
   endtask

   task automatic test_random();
      logic [31:0] exp;
      bit u_pend = 0, m_pend = 0;
      idle_inputs();
      for (int i = 0; i < 400; i++) begin
         reset_i = ($urandom_range(0, 149) == 0);
         clear_i = ($urandom_range(0, 39) == 0);
         // Requests stay stable until accepted
         if (!u_pend) begin ucode_v_i = 1'($urandom); rand_ucode(); end
         if (!m_pend) begin mem_v_i = 1'($urandom); rand_mem(); end
         @(negedge clk_i); exp = model_out(); n_checks++;
         if (act_vec !== exp) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, act_vec, exp); end
         u_pend = ucode_v_i && !exp[1] && !reset_i;
         m_pend = mem_v_i && !exp[0] && !reset_i;
         advance();
      end
      reset_i = 0;
      idle_inputs();
   endtask

   initial begin
      reset_i = 1;
      idle_inputs();
      test_reset();
      test_ucode_only();
      test_conflict();
      test_clear_pulse();
      test_reset_mid_clear();
      test_mem_fields();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_cce_spec_wr_arbiter.md
Name: bp_cce_spec_wr_arbiter

Overview:
Owns the single write port of the CCE speculation-bits array and shares it between two requesters: the microcode engine (instruction-driven spec/squash/fwd_mod/state updates) and the memory-response path (speculation resolution). After reset, or on request, it also runs a clear sequencer that walks every way group and zeroes its metadata. It sits between the CCE instruction decode/memory-response logic and the speculation-bits storage.

Parameters:
num_way_groups_p, "inv", number of way groups in the speculation-bits array; must be ≥ 2.
addr_width_p, "inv", physical address width of the write port.
starve_limit_p, 4, consecutive ucode losses after which ucode wins the next conflict; must be ≥ 1.
Derived: lg_num_way_groups_lp = `BSG_SAFE_CLOG2(num_way_groups_p).

Ports:
clk_i  in  1  clock; all state updates on its rising edge.
reset_i  in  1  reset; synchronous, active-high.
clear_i  in  1  request to re-run the clear sequence.
ucode_v_i  in  1  ucode write request valid.
ucode_ready_o  out  1  ucode request accepted this cycle.
ucode_addr_i  in  addr_width_p  ucode write address.
ucode_bypass_hash_i  in  1  ucode address is a direct way-group index.
ucode_field_v_i  in  4  field write enables {state,fwd_mod,squash,spec}.
ucode_spec_i  in  bp_cce_spec_s  ucode write data.
mem_v_i / mem_ready_o / mem_addr_i / mem_bypass_hash_i / mem_field_v_i / mem_spec_i  same widths and meanings as the ucode group, for the memory-response requester.
w_v_o  out  1  write valid to the spec-bits array.
w_addr_o  out  addr_width_p  write address.
w_addr_bypass_hash_o  out  1  bypass-hash select.
spec_v_o, squash_v_o, fwd_mod_v_o, state_v_o  out  1 each  per-field write enables.
spec_o  out  bp_cce_spec_s  write data.
busy_o  out  1  arbiter not in READY.
clear_done_o  out  1  one-cycle pulse in the first READY cycle after a clear.

Behaviour:
- FSM states: RESET, CLEAR, READY. Next state is RESET whenever reset_i=1, including mid-CLEAR or mid-arbitration. The clear counter and the starvation counter both reset to 0.
- RESET: all outputs 0 except busy_o=1. Transition to CLEAR on the first cycle with reset_i=0.
- CLEAR:
  - Outputs: w_v_o=1, w_addr_bypass_hash_o=1, w_addr_o = zero-extended clear counter, all four field enables=1, spec_o='0.
  - Both ready outputs are 0. busy_o=1. clear_i is ignored.
  - The counter increments every cycle.
  - When the counter equals num_way_groups_p-1, that write is issued, the counter returns to 0, and the next state is READY.
  - The sequence takes exactly num_way_groups_p cycles.
- READY:
  - busy_o=0. clear_done_o=1 only in the first READY cycle following CLEAR; it is registered.
  - clear_i=1 means no grant that cycle (both ready outputs 0, w_v_o=0) and the next state is CLEAR.
- Arbitration in READY, combinational, same cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: mem is granted unless starve_cnt == starve_limit_p, in which case ucode is granted.
  - Neither valid: w_v_o=0 and all field enables are 0.
- Handshake: valid-then-ready. ready_o may depend on the same requester's v_i. A transfer occurs when v_i & ready_o. The requester must hold its request stable until accepted.
- Granted request: w_v_o=1. addr, bypass, spec_o and the field enables {state_v_o,fwd_mod_v_o,squash_v_o,spec_v_o} = granted field_v are passed through unchanged. The write latency to the array is 0 cycles, because the array forwards writes to reads.
- starve_cnt, width `BSG_SAFE_CLOG2(starve_limit_p+1):
  - Increments, saturating at starve_limit_p, when ucode_v_i=1 in READY and ucode is not granted.
  - Clears to 0 when ucode is granted, or when ucode_v_i=0.
  - Holds through CLEAR.

Test Plan:
Use num_way_groups_p=8 and starve_limit_p=3 throughout.
1. Reset: hold reset_i for 3 cycles, then release.
   - Required: 8 consecutive cycles with w_v_o=1, bypass=1, w_addr_o=0..7, all field enables 1, spec_o=0.
   - Then busy_o=0 and clear_done_o=1 for exactly one cycle.
2. Ucode only: ucode_v_i=1, addr=0x1000, field_v=4'b0001, spec_i.spec=1.
   - Required: same-cycle ucode_ready_o=1, w_v_o=1, w_addr_o=0x1000, spec_v_o=1, other enables 0.
3. Conflict: both valid continuously.
   - Required grants are mem, mem, mem, ucode, mem, mem, mem, ucode.
4. clear_i pulse in READY with both requesters valid.
   - Required: no grant that cycle, then an 8-cycle clear with both ready outputs 0.
   - After the clear, grants resume with starve_cnt preserved.
5. Reset asserted at clear counter=4.
   - Required: the next cycle has w_v_o=0.
   - After release, the clear restarts from address 0 and runs a full 8 cycles.
6. mem_v_i=1 with field_v=4'b1010: state_v_o=1, squash_v_o=1, spec_v_o=0, fwd_mod_v_o=0, spec_o equal to mem_spec_i.
